// File: rtl/launch_pkg.sv
// Shared definitions for the UART launch path: FSM encoding and size limits.
package launch_pkg;

    localparam int LAUNCH_MAX_LEN = 254;
    localparam int RAM_AW         = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FILL      = 3'd1,
        ST_DRAIN     = 3'd2,
        ST_LAUNCH    = 3'd3,
        ST_WAIT_DONE = 3'd4
    } launch_state_e;

endpackage

// File: rtl/launch_arbiter_rr.sv
// Combinational round-robin pick: first set request above last_i, wrapping.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    // Scan upward from last_i+1 and take the first requester found.
    always_comb begin
        int  cand;
        logic found;
        onehot_o = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand     = 0;
        for (int off = 1; off <= N; off++) begin
            cand = (int'(last_i) + off) % N;
            if (!found && req_i[cand]) begin
                found          = 1'b1;
                onehot_o[cand] = 1'b1;
                idx_o          = IW'(cand);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/launch_arbiter.sv
// Shares the launch RAM / UART launcher between NUM_REQ byte-stream producers.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// IDLE      | no owner; round-robin pick on any req_valid
// FILL      | owner streams bytes into launch RAM from address 0
// DRAIN     | packet hit MAX_LEN; swallow bytes until req_last
// LAUNCH    | RAM complete; wait for launcher idle, then pulse start
// WAIT_DONE | launcher transmitting; everyone held off until done
module launch_arbiter
    import launch_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int MAX_LEN = LAUNCH_MAX_LEN
) (
    input  logic                 CLK100MHZ,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 ram_en_write,
    output logic [RAM_AW-1:0]    ram_address,
    output logic [7:0]           ram_data_in,
    output logic                 launch_start,
    output logic [7:0]           launch_len,
    input  logic                 launch_busy,
    input  logic                 launch_done,
    output logic                 overflow_err
);

    localparam int         IW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    launch_state_e        state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]        gidx_q, gidx_d;
    logic [IW-1:0]        last_q, last_d;
    logic [7:0]           count_q, count_d;
    logic                 wr_en_q, wr_en_d;
    logic [RAM_AW-1:0]    wr_addr_q, wr_addr_d;
    logic [7:0]           wr_data_q, wr_data_d;
    logic                 start_q, start_d;
    logic [7:0]           len_q, len_d;
    logic                 ovf_q, ovf_d;

    logic [NUM_REQ-1:0]   pick_oh;
    logic [IW-1:0]        pick_idx;
    logic                 pick_any;
    logic                 hs;
    logic [7:0]           sel_byte;
    logic                 sel_last;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
        .req_i    (req_valid),
        .last_i   (last_q),
        .onehot_o (pick_oh),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    // Ready follows the grant only while the owner may still push bytes.
    assign req_ready = (state_q == ST_FILL || state_q == ST_DRAIN) ? grant_q : '0;
    assign hs        = |(req_valid & req_ready);
    assign sel_byte  = req_data[{gidx_q, 3'b000} +: 8];
    assign sel_last  = req_last[gidx_q];

    assign grant        = grant_q;
    assign ram_en_write = wr_en_q;
    assign ram_address  = wr_addr_q;
    assign ram_data_in  = wr_data_q;
    assign launch_start = start_q;
    assign launch_len   = len_q;
    assign overflow_err = ovf_q;

    // Next-state, RAM write and launch control.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        last_d    = last_q;
        count_d   = count_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        start_d   = 1'b0;
        len_d     = len_q;
        ovf_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_oh;
                    gidx_d  = pick_idx;
                    count_d = '0;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (hs) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = count_q;
                    wr_data_d = sel_byte;
                    count_d   = count_q + 8'd1;
                    if (sel_last) begin
                        state_d = ST_LAUNCH;
                    end else if (count_q + 8'd1 == MAX_LEN_B) begin
                        ovf_d   = 1'b1;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (hs && sel_last) begin
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (!launch_busy) begin
                    start_d = 1'b1;
                    len_d   = count_q;
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (launch_done) begin
                    last_d  = gidx_q;
                    grant_d = '0;
                    len_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts any packet or launch in flight.
    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            last_q    <= IW'(NUM_REQ - 1);
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            start_q   <= 1'b0;
            len_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            last_q    <= last_d;
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            start_q   <= start_d;
            len_q     <= len_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_launch_arbiter.sv
// Directed bench for launch_arbiter with a simple auto-responding launcher.
module tb_launch_arbiter;

    logic        clk;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic [1:0]  grant;
    logic        ram_en_write;
    logic [7:0]  ram_address;
    logic [7:0]  ram_data_in;
    logic        launch_start;
    logic [7:0]  launch_len;
    logic        launch_busy;
    logic        launch_done;
    logic        overflow_err;

    launch_arbiter #(.NUM_REQ(2), .MAX_LEN(254)) dut (
        .CLK100MHZ    (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .grant        (grant),
        .ram_en_write (ram_en_write),
        .ram_address  (ram_address),
        .ram_data_in  (ram_data_in),
        .launch_start (launch_start),
        .launch_len   (launch_len),
        .launch_busy  (launch_busy),
        .launch_done  (launch_done),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Observed activity, recorded on the falling edge.
    logic [7:0] mem [256];
    int         wr_addr_log [4096];
    logic [7:0] len_log   [64];
    logic [1:0] grant_log [64];
    int         done_log  [64];
    int         cyc_log   [64];
    int wr_cnt = 0, ovf_cnt = 0, start_cnt = 0, done_cnt = 0, len_unstable = 0;
    int cyc = 0;
    logic       in_flight = 1'b0;
    logic [7:0] cur_len = 8'd0;
    bit         auto_en = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ram_en_write) begin
            mem[ram_address] <= ram_data_in;
            if (wr_cnt < 4096) wr_addr_log[wr_cnt] <= int'(ram_address);
            wr_cnt <= wr_cnt + 1;
        end
        if (overflow_err) ovf_cnt <= ovf_cnt + 1;
        if (in_flight && launch_len != cur_len) len_unstable <= len_unstable + 1;
        if (launch_done) begin
            done_cnt  <= done_cnt + 1;
            in_flight <= 1'b0;
        end
        if (launch_start) begin
            if (start_cnt < 64) begin
                len_log[start_cnt]   <= launch_len;
                grant_log[start_cnt] <= grant;
                done_log[start_cnt]  <= done_cnt;
                cyc_log[start_cnt]   <= cyc;
            end
            start_cnt <= start_cnt + 1;
            in_flight <= 1'b1;
            cur_len   <= launch_len;
        end
    end

    // Launcher model: reports completion a few cycles after each start.
    initial begin
        launch_done = 1'b0;
        forever begin
            @(negedge clk);
            if (launch_start && auto_en) begin
                repeat (4) @(posedge clk);
                #1 launch_done = 1'b1;
                @(posedge clk);
                #1 launch_done = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Push len bytes base, base+1, ... on requester r; entered and left at posedge+1.
    task automatic send_pkt(input int r, input int len, input logic [7:0] base,
                            input bit with_last, output bit ok);
        int t;
        bit rdy;
        ok = 1'b1;
        for (int k = 0; k < len; k++) begin
            req_valid[r]        = 1'b1;
            req_data[8*r +: 8]  = base + 8'(k);
            req_last[r]         = with_last && (k == len - 1);
            t = 0;
            do begin
                rdy = req_ready[r];
                @(posedge clk);
                #1;
                t++;
            end while (!rdy && t < 2000);
            if (!rdy) begin
                ok = 1'b0;
                break;
            end
        end
        req_valid[r] = 1'b0;
        req_last[r]  = 1'b0;
    endtask

    task automatic wait_done(input int target, input string nm);
        int t;
        t = 0;
        while (done_cnt < target && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (done_cnt < target) chk({nm, "_done_timeout"}, 32'(done_cnt), 32'(target));
    endtask

    typedef struct {
        int         req;
        int         len;
        logic [7:0] base;
        int         exp_wr;
        int         exp_len;
        int         exp_ovf;
    } vec_t;

    vec_t vecs [6];

    initial begin
        bit ok, ok0, ok1;
        int b_wr, b_ovf, b_st, b_dn, bad, fall_cyc;

        vecs[0] = '{0,   3, 8'h41,   3,   3, 0};
        vecs[1] = '{1,   1, 8'h10,   1,   1, 0};
        vecs[2] = '{0, 254, 8'h00, 254, 254, 0};
        vecs[3] = '{1, 255, 8'h80, 254, 254, 1};
        vecs[4] = '{1, 300, 8'h20, 254, 254, 1};
        vecs[5] = '{0,   5, 8'hF0,   5,   5, 0};

        reset_n     = 1'b0;
        req_valid   = '0;
        req_data    = '0;
        req_last    = '0;
        launch_busy = 1'b0;

        // Reset values
        #23;
        chk("rst_grant",     32'(grant), 0);
        chk("rst_ready",     32'(req_ready), 0);
        chk("rst_wr_en",     32'(ram_en_write), 0);
        chk("rst_addr",      32'(ram_address), 0);
        chk("rst_data",      32'(ram_data_in), 0);
        chk("rst_start",     32'(launch_start), 0);
        chk("rst_len",       32'(launch_len), 0);
        chk("rst_ovf",       32'(overflow_err), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        cycles(5);
        chk("idle_grant",    32'(grant), 0);
        chk("idle_writes",   32'(wr_cnt), 0);

        // Contention: both valid at once, requester 0 first after reset
        b_st = start_cnt;
        b_dn = done_cnt;
        fork
            send_pkt(0, 2, 8'hA0, 1'b1, ok0);
            send_pkt(1, 3, 8'hB0, 1'b1, ok1);
        join
        chk("cont_hs0", 32'(ok0), 1);
        chk("cont_hs1", 32'(ok1), 1);
        req_valid[0]   = 1'b1;
        req_data[7:0]  = 8'hC0;
        cycles(2);
        chk("cont_hold_ready", 32'(req_ready), 0);
        chk("cont_hold_grant", 32'(grant), 32'h2);
        send_pkt(0, 2, 8'hC0, 1'b1, ok);
        chk("cont_hs2", 32'(ok), 1);
        wait_done(b_dn + 3, "cont");
        chk("cont_first",  32'(grant_log[b_st]), 32'h1);
        chk("cont_second", 32'(grant_log[b_st+1]), 32'h2);
        chk("cont_third",  32'(grant_log[b_st+2]), 32'h1);
        chk("cont_third_after_done", 32'(done_log[b_st+2]), 32'(b_dn + 2));
        chk("cont_len1", 32'(len_log[b_st]), 2);
        chk("cont_len2", 32'(len_log[b_st+1]), 3);

        // Table-driven single packets including MAX_LEN boundaries
        for (int i = 0; i < 6; i++) begin
            b_wr  = wr_cnt;
            b_ovf = ovf_cnt;
            b_st  = start_cnt;
            b_dn  = done_cnt;
            send_pkt(vecs[i].req, vecs[i].len, vecs[i].base, 1'b1, ok);
            chk($sformatf("v%0d_hs", i), 32'(ok), 1);
            chk($sformatf("v%0d_grant_held", i), 32'(grant), 32'(1 << vecs[i].req));
            wait_done(b_dn + 1, $sformatf("v%0d", i));
            cycles(2);
            chk($sformatf("v%0d_grant_clear", i), 32'(grant), 0);
            chk($sformatf("v%0d_writes", i), 32'(wr_cnt - b_wr), 32'(vecs[i].exp_wr));
            chk($sformatf("v%0d_ovf", i), 32'(ovf_cnt - b_ovf), 32'(vecs[i].exp_ovf));
            chk($sformatf("v%0d_len", i), 32'(len_log[b_st]), 32'(vecs[i].exp_len));
            chk($sformatf("v%0d_first_addr", i), 32'(wr_addr_log[b_wr]), 0);
            chk($sformatf("v%0d_last_addr", i), 32'(wr_addr_log[wr_cnt-1]),
                32'(vecs[i].exp_wr - 1));
            bad = 0;
            for (int a = 0; a < vecs[i].exp_wr; a++)
                if (mem[a] !== vecs[i].base + 8'(a)) bad++;
            chk($sformatf("v%0d_data", i), 32'(bad), 0);
        end

        // Launcher busy: start must follow the cycle busy falls
        b_st = start_cnt;
        b_dn = done_cnt;
        launch_busy = 1'b1;
        send_pkt(0, 2, 8'h60, 1'b1, ok);
        chk("busy_hs", 32'(ok), 1);
        cycles(10);
        chk("busy_no_start", 32'(start_cnt), 32'(b_st));
        launch_busy = 1'b0;
        fall_cyc = cyc;
        wait_done(b_dn + 1, "busy");
        chk("busy_start_cycle", 32'(cyc_log[b_st]), 32'(fall_cyc + 1));
        chk("busy_len", 32'(len_log[b_st]), 2);

        // Abort by reset after 5 bytes
        b_st = start_cnt;
        send_pkt(0, 5, 8'h70, 1'b0, ok);
        chk("abort_hs", 32'(ok), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_grant", 32'(grant), 0);
        chk("abort_ready", 32'(req_ready), 0);
        chk("abort_wr_en", 32'(ram_en_write), 0);
        chk("abort_addr",  32'(ram_address), 0);
        cycles(3);
        reset_n = 1'b1;
        cycles(20);
        chk("abort_no_start", 32'(start_cnt), 32'(b_st));
        b_wr = wr_cnt;
        b_dn = done_cnt;
        send_pkt(1, 3, 8'h55, 1'b1, ok);
        chk("post_hs", 32'(ok), 1);
        wait_done(b_dn + 1, "post");
        chk("post_first_addr", 32'(wr_addr_log[b_wr]), 0);
        chk("post_data0", 32'(mem[0]), 32'h55);
        chk("post_len", 32'(len_log[b_st]), 3);

        chk("len_stable", 32'(len_unstable), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
